// File: rtl/dram_pkg.sv
// Shared types, default geometry and the address-split helper used by the
// DRAM address mapper, its open-row table and its testbench.
package dram_pkg;

    localparam int DEF_ADDR_WIDTH   = 13;
    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_STAT_WIDTH   = 16;
    localparam int DEF_BANK_W       = $clog2(DEF_NUM_OF_BANKS);
    localparam int DEF_ROW_W        = $clog2(DEF_NUM_OF_ROWS);
    localparam int DEF_COL_W        = $clog2(DEF_NUM_OF_COLS);
    localparam int MAP_MODE_W       = 2;
    localparam int ROW_STATUS_W     = 2;
    localparam int SPLIT_W          = 64;

    typedef enum logic [MAP_MODE_W-1:0] {
        MODE_BRC     = 2'd0,
        MODE_RBC     = 2'd1,
        MODE_BRC_XOR = 2'd2
    } map_mode_e;

    typedef enum logic [ROW_STATUS_W-1:0] {
        ROW_MISS     = 2'd0,
        ROW_HIT      = 2'd1,
        ROW_CONFLICT = 2'd2
    } row_status_e;

    // Returns the split packed back as {bank, row, col} in the low bits, so
    // callers slice it with their own widths. Unknown modes fall back to BRC.
    function automatic logic [SPLIT_W-1:0] split_addr(
        input logic [SPLIT_W-1:0] addr,
        input int                 bank_w,
        input int                 row_w,
        input int                 col_w,
        input map_mode_e          mode
    );
        logic [SPLIT_W-1:0] bank_mask;
        logic [SPLIT_W-1:0] row_mask;
        logic [SPLIT_W-1:0] col_mask;
        logic [SPLIT_W-1:0] bank;
        logic [SPLIT_W-1:0] row;
        logic [SPLIT_W-1:0] col;
        bank_mask = (64'd1 << bank_w) - 64'd1;
        row_mask  = (64'd1 << row_w) - 64'd1;
        col_mask  = (64'd1 << col_w) - 64'd1;
        col       = addr & col_mask;
        case (mode)
            MODE_RBC: begin
                row  = (addr >> (bank_w + col_w)) & row_mask;
                bank = (addr >> col_w) & bank_mask;
            end
            MODE_BRC_XOR: begin
                row  = (addr >> col_w) & row_mask;
                bank = ((addr >> (row_w + col_w)) ^ row) & bank_mask;
            end
            default: begin
                row  = (addr >> col_w) & row_mask;
                bank = (addr >> (row_w + col_w)) & bank_mask;
            end
        endcase
        return (bank << (row_w + col_w)) | (row << col_w) | col;
    endfunction

endpackage

// File: rtl/dram_addr_mapper_if.sv
// Request/result bundle between the L2 request queue, the address mapper
// and the DRAM command scheduler.
interface dram_addr_mapper_if
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BANK_W     = DEF_BANK_W,
    parameter int ROW_W      = DEF_ROW_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int STAT_WIDTH = DEF_STAT_WIDTH
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_address;
    logic [MAP_MODE_W-1:0]   map_mode;
    logic                    precharge_all;
    logic                    out_valid;
    logic                    out_ready;
    logic [BANK_W-1:0]       bank_id;
    logic [ROW_W-1:0]        row_id;
    logic [COL_W-1:0]        col_id;
    logic [ROW_STATUS_W-1:0] row_status;
    logic [STAT_WIDTH-1:0]   stat_hits;
    logic [STAT_WIDTH-1:0]   stat_conflicts;

    modport master (
        output req_valid, req_address, map_mode, precharge_all, out_ready,
        input  req_ready, out_valid, bank_id, row_id, col_id, row_status,
               stat_hits, stat_conflicts
    );

    modport slave (
        input  req_valid, req_address, map_mode, precharge_all, out_ready,
        output req_ready, out_valid, bank_id, row_id, col_id, row_status,
               stat_hits, stat_conflicts
    );
endinterface

// File: rtl/dram_open_row_table.sv
// Per-bank open flag and open-row tag with a combinational lookup port.
// A write to a bank wins over a same-cycle clear-all for that bank only.
module dram_open_row_table
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int ROW_W        = DEF_ROW_W,
    localparam int BANK_W      = $clog2(NUM_OF_BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] lookup_bank,
    output logic              lookup_open,
    output logic [ROW_W-1:0]  lookup_row,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic              clear_all
);
    logic [NUM_OF_BANKS-1:0] open_r;
    logic [ROW_W-1:0]        tag_r [NUM_OF_BANKS];

    // Table update: write opens its bank, clear-all closes every other bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_r <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                if (wr_en && (wr_bank == BANK_W'(i))) begin
                    open_r[i] <= 1'b1;
                    tag_r[i]  <= wr_row;
                end else if (clear_all) begin
                    open_r[i] <= 1'b0;
                end else begin
                    open_r[i] <= open_r[i];
                end
            end
        end
    end

    assign lookup_open = open_r[lookup_bank];
    assign lookup_row  = tag_r[lookup_bank];

endmodule

// File: rtl/dram_addr_mapper.sv
// Registered DRAM address mapper: splits accepted L2 addresses into
// bank/row/column and tags each result HIT/MISS/CONFLICT against the open rows.
module dram_addr_mapper
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int STAT_WIDTH   = DEF_STAT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    dram_addr_mapper_if.slave   bus
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);

    generate
        if (ADDR_WIDTH != BANK_W + ROW_W + COL_W) begin : g_bad_addr_width
            $error("dram_addr_mapper: ADDR_WIDTH must equal BANK_W+ROW_W+COL_W");
        end
        if (ROW_W < BANK_W) begin : g_bad_row_width
            $error("dram_addr_mapper: ROW_W must be at least BANK_W");
        end
    endgenerate

    logic                  accept_s;
    logic [SPLIT_W-1:0]    fields_s;
    logic [BANK_W-1:0]     bank_s;
    logic [ROW_W-1:0]      row_s;
    logic [COL_W-1:0]      col_s;
    logic                  tbl_open_s;
    logic [ROW_W-1:0]      tbl_row_s;
    row_status_e           status_s;
    logic                  unused_split_s;

    logic                  out_valid_r;
    logic [BANK_W-1:0]     bank_r;
    logic [ROW_W-1:0]      row_r;
    logic [COL_W-1:0]      col_r;
    row_status_e           status_r;
    logic [STAT_WIDTH-1:0] hits_r;
    logic [STAT_WIDTH-1:0] conflicts_r;

    assign bus.req_ready = !out_valid_r || bus.out_ready;
    assign accept_s      = bus.req_valid && bus.req_ready;

    // Address split under the requested mapping mode.
    always_comb begin
        fields_s = split_addr(SPLIT_W'(bus.req_address), BANK_W, ROW_W, COL_W,
                              map_mode_e'(bus.map_mode));
    end

    assign col_s          = fields_s[COL_W-1:0];
    assign row_s          = fields_s[COL_W +: ROW_W];
    assign bank_s         = fields_s[COL_W + ROW_W +: BANK_W];
    assign unused_split_s = ^fields_s[SPLIT_W-1:ADDR_WIDTH];

    dram_open_row_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .ROW_W        (ROW_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_bank (bank_s),
        .lookup_open (tbl_open_s),
        .lookup_row  (tbl_row_s),
        .wr_en       (accept_s),
        .wr_bank     (bank_s),
        .wr_row      (row_s),
        .clear_all   (bus.precharge_all)
    );

    // Classification against the pre-update entry; a coincident precharge forces MISS.
    always_comb begin
        status_s = ROW_MISS;
        if (bus.precharge_all) begin
            status_s = ROW_MISS;
        end else if (!tbl_open_s) begin
            status_s = ROW_MISS;
        end else if (tbl_row_s == row_s) begin
            status_s = ROW_HIT;
        end else begin
            status_s = ROW_CONFLICT;
        end
    end

    // Output register: loads on acceptance, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            bank_r      <= '0;
            row_r       <= '0;
            col_r       <= '0;
            status_r    <= ROW_MISS;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            bank_r      <= bank_s;
            row_r       <= row_s;
            col_r       <= col_s;
            status_r    <= status_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_r      <= '0;
            conflicts_r <= '0;
        end else if (accept_s) begin
            if ((status_s == ROW_HIT) && (hits_r != {STAT_WIDTH{1'b1}})) begin
                hits_r <= hits_r + STAT_WIDTH'(1);
            end else if ((status_s == ROW_CONFLICT) &&
                         (conflicts_r != {STAT_WIDTH{1'b1}})) begin
                conflicts_r <= conflicts_r + STAT_WIDTH'(1);
            end else begin
                hits_r      <= hits_r;
                conflicts_r <= conflicts_r;
            end
        end else begin
            hits_r      <= hits_r;
            conflicts_r <= conflicts_r;
        end
    end

    assign bus.out_valid      = out_valid_r;
    assign bus.bank_id        = bank_r;
    assign bus.row_id         = row_r;
    assign bus.col_id         = col_r;
    assign bus.row_status     = status_r;
    assign bus.stat_hits      = hits_r;
    assign bus.stat_conflicts = conflicts_r;

endmodule

// File: tb/tb_dram_addr_mapper.sv
// Scoreboard bench for dram_addr_mapper: an independent bit-slice and
// open-row model predicts every result, compared when the DUT hands it off.
module tb_dram_addr_mapper;
    localparam int SW = 4;

    typedef struct packed {
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic [1:0] st;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    logic          m_open [8];
    logic [6:0]    m_row  [8];
    logic [SW-1:0] m_hits;
    logic [SW-1:0] m_conf;

    dram_addr_mapper_if #(.ADDR_WIDTH(13), .BANK_W(3), .ROW_W(7), .COL_W(3),
                          .STAT_WIDTH(SW)) bus ();

    dram_addr_mapper #(.ADDR_WIDTH(13), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128),
                       .NUM_OF_COLS(8), .STAT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 7'd0;
        end
        m_hits = '0;
        m_conf = '0;
    endtask

    // Drive one request; push the prediction on the cycle it is accepted.
    task automatic send(input logic [12:0] a, input logic [1:0] m, input logic pc);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus.req_valid     = 1'b1;
        bus.req_address   = a;
        bus.map_mode      = m;
        bus.precharge_all = pc;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                e.col = a[2:0];
                case (m)
                    2'd1: begin e.row = a[12:6]; e.bank = a[5:3]; end
                    2'd2: begin e.row = a[9:3];  e.bank = a[12:10] ^ a[5:3]; end
                    default: begin e.row = a[9:3]; e.bank = a[12:10]; end
                endcase
                if (pc)                        e.st = 2'd0;
                else if (!m_open[e.bank])      e.st = 2'd0;
                else if (m_row[e.bank] == e.row) e.st = 2'd1;
                else                           e.st = 2'd2;
                if (e.st == 2'd1 && m_hits != '1) m_hits = m_hits + 1'b1;
                if (e.st == 2'd2 && m_conf != '1) m_conf = m_conf + 1'b1;
                if (pc) for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                m_open[e.bank] = 1'b1;
                m_row[e.bank]  = e.row;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
        bus.req_valid     = 1'b0;
        bus.precharge_all = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 40 && !empty; k++) begin
            @(posedge clk);
            #2;
            empty = (sb.size() == 0) && !bus.out_valid;
        end
        if (!empty) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: each handoff seen between edges is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("bank_id", 32'(bus.bank_id), 32'(e.bank));
                check_eq("row_id", 32'(bus.row_id), 32'(e.row));
                check_eq("col_id", 32'(bus.col_id), 32'(e.col));
                check_eq("row_status", 32'(bus.row_status), 32'(e.st));
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_address   = 13'd0;
        bus.map_mode      = 2'd0;
        bus.precharge_all = 1'b0;
        bus.out_ready     = 1'b1;
        model_reset();
        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_bank", 32'(bus.bank_id), 32'd0);
        check_eq("rst_row", 32'(bus.row_id), 32'd0);
        check_eq("rst_col", 32'(bus.col_id), 32'd0);
        check_eq("rst_status", 32'(bus.row_status), 32'd0);
        check_eq("rst_hits", 32'(bus.stat_hits), 32'd0);
        check_eq("rst_conf", 32'(bus.stat_conflicts), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Row tracking: MISS, HIT, CONFLICT.
        send(13'h1A5, 2'd0, 1'b0);
        send(13'h1A0, 2'd0, 1'b0);
        send(13'h1C5, 2'd0, 1'b0);
        drain();
        check_eq("track_hits", 32'(bus.stat_hits), 32'd1);
        check_eq("track_conf", 32'(bus.stat_conflicts), 32'd1);

        // Mapping modes on 0x1A5, including the reserved encoding.
        for (int m = 1; m < 4; m++) send(13'h1A5, 2'(m), 1'b0);
        drain();

        // Backpressure: one result parked while the next request waits.
        bus.out_ready = 1'b0;
        send(13'h1A5, 2'd0, 1'b0);
        fork
            send(13'h0A3, 2'd0, 1'b0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq("bp_ready", 32'(bus.req_ready), 32'd0);
                    check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
                    check_eq("bp_bank", 32'(bus.bank_id), 32'd0);
                    check_eq("bp_row", 32'(bus.row_id), 32'h34);
                    check_eq("bp_col", 32'(bus.col_id), 32'd5);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        send(13'h1FF, 2'd0, 1'b0);
        drain();

        // Precharge coincident with acceptance, then standalone precharge.
        send(13'h1A5, 2'd0, 1'b0);
        send(13'h1A0, 2'd0, 1'b1);
        send(13'h1A0, 2'd0, 1'b0);
        bus.precharge_all = 1'b1;
        @(posedge clk);
        #1;
        bus.precharge_all = 1'b0;
        for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
        send(13'h1A0, 2'd0, 1'b0);
        drain();
        check_eq("pc_hits", 32'(bus.stat_hits), 32'(m_hits));
        check_eq("pc_conf", 32'(bus.stat_conflicts), 32'(m_conf));

        // Legacy sweep over the whole address space; counters saturate.
        for (int a = 0; a < 8192; a++) send(13'(a), 2'd0, 1'b0);
        drain();
        check_eq("sat_hits", 32'(bus.stat_hits), 32'(m_hits));
        check_eq("sat_conf", 32'(bus.stat_conflicts), 32'(m_conf));
        check_eq("sat_hits_max", 32'(bus.stat_hits), 32'hF);

        // Reset with a result in flight.
        bus.out_ready = 1'b0;
        send(13'h1A5, 2'd0, 1'b0);
        check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_hits", 32'(bus.stat_hits), 32'd0);
        check_eq("mid_rst_conf", 32'(bus.stat_conflicts), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(13'h1A5, 2'd0, 1'b0);
        drain();
        check_eq("post_rst_hits", 32'(bus.stat_hits), 32'd0);
        check_eq("post_rst_conf", 32'(bus.stat_conflicts), 32'd0);
        check_eq("sb_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
